// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg: shared state/op types and the radix-2 Booth pair decoder
package booth_mult_pkg;

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, HOLD} state_t;
    typedef enum logic [1:0] {NOP, ADDOP, SUBOP} booth_op_t;

    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        return (q0 == qm1) ? NOP : (q0 ? SUBOP : ADDOP);
    endfunction

endpackage

// File: rtl/mult_iter_cnt.sv
// mult_iter_cnt: Booth iteration counter with clear, enable and terminal count at WIDTH-1
module mult_iter_cnt #(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = cnt == CW'(WIDTH - 1);

endmodule

// File: rtl/booth_mult_sequencer.sv
// booth_mult_sequencer: radix-2 Booth control FSM driving the A/B/X add-shift datapath
module booth_mult_sequencer
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic Q0,
    output logic ClearA,
    output logic LoadA,
    output logic ShiftA,
    output logic LoadB,
    output logic ShiftB,
    output logic ClearX,
    output logic LoadX,
    output logic ShiftX,
    output logic Sub_Add,
    output logic Busy,
    output logic Done
);

    state_t    state, state_nxt;
    booth_op_t op;
    logic      qm1, tc, start;

    assign start = (state == IDLE) && Run;
    assign op    = booth_decode(Q0, qm1);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            qm1   <= 1'b0;
        end else begin
            state <= state_nxt;
            qm1   <= start ? 1'b0 : (state == SHIFT) ? Q0 : qm1;
        end
    end

    mult_iter_cnt #(.WIDTH(WIDTH)) u_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (start),
        .en    (state == SHIFT),
        .tc    (tc)
    );

    always_comb begin
        state_nxt = state;
        ClearA    = 1'b0;
        LoadA     = 1'b0;
        ShiftA    = 1'b0;
        LoadB     = 1'b0;
        ShiftB    = 1'b0;
        ClearX    = 1'b0;
        LoadX     = 1'b0;
        ShiftX    = 1'b0;
        Sub_Add   = 1'b0;
        Busy      = (state == ADD) || (state == SHIFT);
        Done      = state == HOLD;
        case (state)
            IDLE: begin
                state_nxt = Run ? ADD : IDLE;
                ClearA    = Run | ClearA_LoadB;
                ClearX    = Run | ClearA_LoadB;
                LoadB     = !Run && ClearA_LoadB;
            end
            ADD: begin
                state_nxt = SHIFT;
                LoadA     = op != NOP;
                LoadX     = op != NOP;
                Sub_Add   = op == SUBOP;
            end
            SHIFT: begin
                state_nxt = tc ? HOLD : ADD;
                ShiftA    = 1'b1;
                ShiftB    = 1'b1;
                ShiftX    = 1'b1;
            end
            HOLD: state_nxt = Run ? HOLD : IDLE;
        endcase
        // Reset is asynchronous, so the outputs must drop with it rather than wait for the state flop.
        if (!Reset) begin
            ClearA  = 1'b0;
            LoadA   = 1'b0;
            ShiftA  = 1'b0;
            LoadB   = 1'b0;
            ShiftB  = 1'b0;
            ClearX  = 1'b0;
            LoadX   = 1'b0;
            ShiftX  = 1'b0;
            Sub_Add = 1'b0;
            Busy    = 1'b0;
            Done    = 1'b0;
        end
    end

endmodule

// File: doc/booth_mult_sequencer.md
# booth_mult_sequencer

Sequencer for the lab's add-shift multiplier datapath (A/B shift registers, sign-extension bit X, WIDTH-bit adder/subtractor). It runs radix-2 Booth recoding. It owns the iteration counter and the Booth history bit Q₋₁, and it splits each iteration into an ADD cycle and a SHIFT cycle. It sits between the top-level switch/button logic and the register and adder control pins, and raises Busy/Done for the display and top level.

## Interface
- WIDTH, 8, operand width and number of Booth iterations (≥2)
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Run  in  1  start request, level-sensitive; one operation per high pulse
- ClearA_LoadB  in  1  idle-only request: clear A/X, load B from switches
- Q0  in  1  current LSB of B register
- ClearA, LoadA, ShiftA  out  1 each  A register controls
- LoadB, ShiftB  out  1 each  B register controls
- ClearX, LoadX, ShiftX  out  1 each  X (sign) bit controls
- Sub_Add  out  1  adder mode: 1 = A − S, 0 = A + S
- Busy  out  1  high in ADD and SHIFT
- Done  out  1  high in HOLD

## Operation
- States: IDLE, ADD, SHIFT, HOLD. Registers: state, cnt (clog2(WIDTH) bits), qm1.
- IDLE:
  - Run=1: assert ClearA and ClearX, clear qm1 and cnt, go to ADD. Run has priority over ClearA_LoadB, so LoadB stays 0.
  - Run=0 and ClearA_LoadB=1: assert ClearA, ClearX, LoadB. Stay in IDLE.
  - Otherwise: all controls 0.
- ADD: Booth pair {Q0, qm1}.
  - 10: LoadA=LoadX=1, Sub_Add=1.
  - 01: LoadA=LoadX=1, Sub_Add=0.
  - 00 or 11: no load, Sub_Add=0.
  - Always go to SHIFT.
- SHIFT: ShiftA=ShiftB=ShiftX=1, qm1←Q0, cnt←cnt+1. If cnt==WIDTH−1, go to HOLD, else to ADD.
- HOLD: Done=1, all datapath controls 0. Go to IDLE on Run=0; otherwise stay.
- Sub_Add is 0 in every state and case not listed above.
- Counter wrap: cnt is never compared beyond WIDTH−1 and resets to 0 on start.
- Only IDLE depends on Run and ClearA_LoadB for its outputs. All other outputs depend only on state and {Q0, qm1}.

## Timing
- Reset low:
  - Immediately (asynchronously) forces state=IDLE, cnt=0, qm1=0.
  - All outputs read 0 while Reset is low: ClearA, LoadA, ShiftA, LoadB, ShiftB, ClearX, LoadX, ShiftX, Sub_Add, Busy, Done.
  - Releasing Reset mid-operation starts from IDLE. No partial operation resumes.
- Start cycle (IDLE with Run=1) is cycle 0.
- Cycles 1..2·WIDTH alternate ADD and SHIFT. Done rises at cycle 2·WIDTH+1 (17 for WIDTH=8).
- Q0 must be stable during ADD and SHIFT. qm1 samples it on the SHIFT edge, the same edge on which B shifts.
- Run held high through HOLD does not retrigger an operation. A new start needs Run low for at least one cycle, then high again.
- Run falling during ADD or SHIFT is ignored. The operation completes, then passes through HOLD for one cycle (Done=1 for exactly one cycle) and returns to IDLE.

## Structure
- Package booth_mult_pkg:
  - state_t enum {IDLE, ADD, SHIFT, HOLD}, 2 bits.
  - booth_op_t enum {NOP, ADDOP, SUBOP}.
  - Function booth_decode(q0, qm1) returning booth_op_t.
- One sub-module: mult_iter_cnt, a WIDTH-parameterised counter with clear, enable, and terminal-count output.
- The FSM, qm1 flop, and output decode stay in booth_mult_sequencer.

## Test plan
- Drive Reset low at cycle 5 of an operation (an ADD with Q0=1, qm1=0) → all outputs 0 at once. After release, state is IDLE and Busy=0.
- In IDLE, drive ClearA_LoadB=1, Run=0 → ClearA=ClearX=LoadB=1 in the same cycle. Drive both high → ClearA=ClearX=1, LoadB=0, next state ADD.
- Start with Q0 held 0, WIDTH=8 → 8 SHIFT pulses, LoadA never asserted, Done first high 17 cycles after the start cycle.
- Start with Q0 held 1 → iteration 0 gives LoadA=1, Sub_Add=1. Iterations 1–7 give no LoadA.
- Drive Q0 as 1,0,1,0,… per iteration → iteration 0 subtracts; iterations 1,3,5,7 add (Sub_Add=0, LoadA=1); iterations 2,4,6 subtract.
- Keep Run high for 5 cycles past Done → stays in HOLD with Done=1, no restart. Drop Run → IDLE next cycle. Raise Run again → new start, cnt=0.
